cp_fifo_fetch: RTL and testbench

CP_FIFO_FETCH -- requirements
Module: cp_fifo_fetch

---
 rtl/cp_pkg.sv | 28 ++
 rtl/cp_beat_fifo.sv | 60 ++++++
 rtl/cp_fifo_fetch.sv | 208 ++++++++++++++++++++
 tb/tb_cp_fifo_fetch.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// Shared types and constants for the command-processor FIFO fetch block.
package cp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } cp_state_e;

    localparam int unsigned CP_BLOCK_BYTES    = 32;
    localparam logic [1:0]  CP_AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  CP_AXI_SIZE_16B   = 3'b100;
    localparam logic [3:0]  CP_AXI_LEN_2BEAT  = 4'd1;
    localparam logic [1:0]  CP_AXI_RESP_OKAY  = 2'b00;

    function automatic logic [31:0] cp_block_align(input logic [31:0] addr);
        return addr & ~32'(CP_BLOCK_BYTES - 1);
    endfunction

    // The block at fifo_end is the last one fetched before wrapping to base.
    function automatic logic [31:0] cp_next_rptr(input logic [31:0] rptr,
                                                 input logic [31:0] base,
                                                 input logic [31:0] fend);
        return (rptr == fend) ? base : rptr + 32'(CP_BLOCK_BYTES);
    endfunction

endpackage

// File: rtl/cp_beat_fifo.sv
// Synchronous beat buffer with flush; a write at full succeeds when a read
// happens in the same cycle.
module cp_beat_fifo
    import cp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 128,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/cp_fifo_fetch.sv
// Fetches 32-byte blocks of the GX command FIFO over AXI and streams them out
// as 32-bit words. Breakpoint support is built when CP_FIFO_BREAKPOINT_EN is defined.
module cp_fifo_fetch
    import cp_pkg::*;
#(
    parameter int unsigned BUF_BEATS = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         enable,
    input  logic [31:0]  fifo_base,
    input  logic [31:0]  fifo_end,
    input  logic [31:0]  fifo_wptr,
    input  logic         rptr_load,
    input  logic [31:0]  rptr_load_value,
    output logic [31:0]  rptr,
    output logic         fifo_empty,
    output logic [31:0]  araddrm_a,
    output logic [1:0]   arburstm_a,
    output logic [3:0]   arlenm_a,
    output logic [2:0]   arsizem_a,
    output logic         arvalidm_a,
    input  logic         arreadym_a,
    input  logic [127:0] rdatam_a,
    input  logic [1:0]   rrespm_a,
    input  logic         rlastm_a,
    input  logic         rvalidm_a,
    output logic         rreadym_a,
    output logic [31:0]  cmd_data,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic         bus_err,
    input  logic         bp_en,
    input  logic [31:0]  bp_addr,
    output logic         bp_hit
);

    localparam int unsigned CW = $clog2(BUF_BEATS) + 1;

    cp_state_e      state_q, state_d;
    logic [31:0]    rptr_q, rptr_d;
    logic           pend_q, pend_d;
    logic [31:0]    pend_val_q, pend_val_d;
    logic           bus_err_q, bus_err_d;
    logic           burst_err_q, burst_err_d;
    logic [1:0]     word_q, word_d;

    logic           buf_wr;
    logic           buf_rd;
    logic           buf_flush;
    logic           buf_full;
    logic           buf_empty;
    logic [CW-1:0]  buf_count;
    logic [CW-1:0]  buf_free;
    logic [127:0]   buf_head;
    logic           cmd_fire;
    logic           bad_resp;
    logic           bp_block;

    cp_beat_fifo #(
        .DEPTH (BUF_BEATS),
        .WIDTH (128)
    ) u_beat_fifo (
        .clk       (clk),
        .rst_n     (resetn),
        .flush_i   (buf_flush),
        .wr_en_i   (buf_wr),
        .wr_data_i (rdatam_a),
        .rd_en_i   (buf_rd),
        .rd_data_o (buf_head),
        .full_o    (buf_full),
        .empty_o   (buf_empty),
        .count_o   (buf_count)
    );

    assign rptr       = rptr_q;
    assign fifo_empty = (rptr_q == fifo_wptr);
    assign bus_err    = bus_err_q;
    assign araddrm_a  = cp_block_align(rptr_q);
    assign arburstm_a = CP_AXI_BURST_INCR;
    assign arlenm_a   = CP_AXI_LEN_2BEAT;
    assign arsizem_a  = CP_AXI_SIZE_16B;
    assign buf_free   = CW'(BUF_BEATS) - buf_count;
    assign bad_resp   = (rrespm_a != CP_AXI_RESP_OKAY);

    // Output side works purely from registered buffer state, never from cmd_ready.
    assign cmd_valid  = !buf_empty;
    assign cmd_data   = buf_empty ? 32'h0 : buf_head[{word_q, 5'b0} +: 32];
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign buf_rd     = cmd_fire && (word_q == 2'd3);

`ifdef CP_FIFO_BREAKPOINT_EN
    logic bp_hit_q;

    assign bp_block = bp_hit_q || (bp_en && (rptr_q == bp_addr));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bp_hit_q <= 1'b0;
        end else if (!bp_en) begin
            bp_hit_q <= 1'b0;
        end else if ((state_q == IDLE) && (rptr_q == bp_addr)) begin
            bp_hit_q <= 1'b1;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    logic unused_bp;

    assign unused_bp = ^{bp_en, bp_addr};
    assign bp_block  = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rptr_d      = rptr_q;
        pend_d      = pend_q;
        pend_val_d  = pend_val_q;
        bus_err_d   = bus_err_q;
        burst_err_d = burst_err_q;
        word_d      = cmd_fire ? word_q + 2'd1 : word_q;
        buf_wr      = 1'b0;
        buf_flush   = 1'b0;
        arvalidm_a  = 1'b0;
        rreadym_a   = 1'b0;

        case (state_q)
            IDLE: begin
                // A fresh load beats an older pending one; both flush stale words.
                if (rptr_load) begin
                    rptr_d    = cp_block_align(rptr_load_value);
                    pend_d    = 1'b0;
                    buf_flush = 1'b1;
                    word_d    = 2'd0;
                end else if (pend_q) begin
                    rptr_d    = cp_block_align(pend_val_q);
                    pend_d    = 1'b0;
                    buf_flush = 1'b1;
                    word_d    = 2'd0;
                end else if (enable && !fifo_empty && !buf_full &&
                             (buf_free >= CW'(2)) && !bp_block && !bus_err_q) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                arvalidm_a = 1'b1;
                if (arreadym_a) state_d = DATA;
            end
            DATA: begin
                rreadym_a = 1'b1;
                if (rvalidm_a) begin
                    if (bad_resp) begin
                        bus_err_d   = 1'b1;
                        burst_err_d = 1'b1;
                    end else if (!burst_err_q) begin
                        buf_wr = 1'b1;
                    end
                    if (rlastm_a) begin
                        burst_err_d = 1'b0;
                        if (burst_err_q || bad_resp) begin
                            state_d = ERR;
                        end else begin
                            rptr_d  = cp_next_rptr(rptr_q, fifo_base, fifo_end);
                            state_d = IDLE;
                        end
                    end
                end
            end
            ERR: begin
                if (!enable) begin
                    bus_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && rptr_load) begin
            pend_d     = 1'b1;
            pend_val_d = rptr_load_value;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rptr_q      <= 32'h0;
            pend_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            burst_err_q <= 1'b0;
            word_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            rptr_q      <= rptr_d;
            pend_q      <= pend_d;
            bus_err_q   <= bus_err_d;
            burst_err_q <= burst_err_d;
            word_q      <= word_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_val_q <= pend_val_d;
    end

endmodule

// File: tb/tb_cp_fifo_fetch.sv
// Directed bench for cp_fifo_fetch with a small AXI read slave and word collector.
module tb_cp_fifo_fetch;

    localparam int unsigned BUF_BEATS = 4;
    localparam logic [31:0] PAT       = 32'hA5A5_0000;

    logic         clk = 1'b0;
    logic         resetn;
    logic         enable;
    logic [31:0]  fifo_base, fifo_end, fifo_wptr;
    logic         rptr_load;
    logic [31:0]  rptr_load_value;
    logic [31:0]  rptr;
    logic         fifo_empty;
    logic [31:0]  araddrm_a;
    logic [1:0]   arburstm_a;
    logic [3:0]   arlenm_a;
    logic [2:0]   arsizem_a;
    logic         arvalidm_a;
    logic         arreadym_a;
    logic [127:0] rdatam_a;
    logic [1:0]   rrespm_a;
    logic         rlastm_a;
    logic         rvalidm_a;
    logic         rreadym_a;
    logic [31:0]  cmd_data;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         bus_err;
    logic         bp_en;
    logic [31:0]  bp_addr;
    logic         bp_hit;

    int checks = 0;
    int passes = 0;

    logic [31:0] arq[$];
    logic [31:0] wq[$];
    logic        err_inject;

    always #5 clk = ~clk;

    cp_fifo_fetch #(.BUF_BEATS(BUF_BEATS)) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .fifo_base(fifo_base), .fifo_end(fifo_end), .fifo_wptr(fifo_wptr),
        .rptr_load(rptr_load), .rptr_load_value(rptr_load_value),
        .rptr(rptr), .fifo_empty(fifo_empty),
        .araddrm_a(araddrm_a), .arburstm_a(arburstm_a), .arlenm_a(arlenm_a),
        .arsizem_a(arsizem_a), .arvalidm_a(arvalidm_a), .arreadym_a(arreadym_a),
        .rdatam_a(rdatam_a), .rrespm_a(rrespm_a), .rlastm_a(rlastm_a),
        .rvalidm_a(rvalidm_a), .rreadym_a(rreadym_a),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .bus_err(bus_err), .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit)
    );

    function automatic logic [127:0] beat_data(input logic [31:0] a);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[i*32 +: 32] = (a + 32'(4*i)) ^ PAT;
        return d;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ PAT;
    endfunction

    // AXI read slave: one-cycle AR accept, then two back-to-back beats.
    initial begin : slave
        logic [31:0] a;
        arreadym_a = 1'b0;
        rvalidm_a  = 1'b0;
        rlastm_a   = 1'b0;
        rrespm_a   = 2'b00;
        rdatam_a   = '0;
        err_inject = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (arvalidm_a && resetn) begin
                a = araddrm_a;
                arq.push_back(a);
                arreadym_a = 1'b1;
                @(posedge clk); #1;
                arreadym_a = 1'b0;
                for (int b = 0; b < 2; b++) begin
                    rvalidm_a = 1'b1;
                    rlastm_a  = (b == 1);
                    rrespm_a  = (err_inject && b == 0) ? 2'd2 : 2'd0;
                    rdatam_a  = beat_data(a + 32'(16*b));
                    @(posedge clk); #1;
                end
                rvalidm_a  = 1'b0;
                rlastm_a   = 1'b0;
                rrespm_a   = 2'b00;
                err_inject = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && cmd_valid && cmd_ready) wq.push_back(cmd_data);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_rptr(input logic [31:0] v);
        rptr_load       = 1'b1;
        rptr_load_value = v;
        cyc(1);
        rptr_load = 1'b0;
        cyc(1);
    endtask

    task automatic wait_data(input string tag);
        bit found;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (rreadym_a) found = 1;
        end
        checks++;
        if (!found) $display("FAIL %s_reach_data: rready got 0 want 1 within 20 cycles", tag);
        else passes++;
        cyc(1);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        cyc(2);
        @(negedge clk);
        checks++; if (rptr !== 32'h0) $display("FAIL reset_rptr: got %h want 0", rptr); else passes++;
        checks++; if (arvalidm_a !== 1'b0) $display("FAIL reset_arvalid: got %b want 0", arvalidm_a); else passes++;
        checks++; if (rreadym_a !== 1'b0) $display("FAIL reset_rready: got %b want 0", rreadym_a); else passes++;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); else passes++;
        checks++; if (cmd_data !== 32'h0) $display("FAIL reset_cmd_data: got %h want 0", cmd_data); else passes++;
        checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else passes++;
        checks++; if (bp_hit !== 1'b0) $display("FAIL reset_bp_hit: got %b want 0", bp_hit); else passes++;
        checks++; if (fifo_empty !== 1'b1) $display("FAIL reset_fifo_empty: got %b want 1", fifo_empty); else passes++;
        cyc(1);
        resetn = 1'b1;
        cyc(1);
    endtask

    task automatic test_basic;
        load_rptr(32'h1000);
        fifo_wptr = 32'h1040;
        cmd_ready = 1'b1;
        arq.delete();
        wq.delete();
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (arvalidm_a !== 1'b1) $display("FAIL basic_ar_latency: arvalid got %b want 1", arvalidm_a); else passes++;
        checks++; if (araddrm_a !== 32'h1000) $display("FAIL basic_araddr: got %h want 00001000", araddrm_a); else passes++;
        checks++; if ({arlenm_a, arsizem_a, arburstm_a} !== {4'd1, 3'b100, 2'b01})
            $display("FAIL basic_ar_attr: got len %0d size %0d burst %0d want 1 4 1", arlenm_a, arsizem_a, arburstm_a);
            else passes++;
        cyc(60);
        @(negedge clk);
        checks++; if (arq.size() != 2) $display("FAIL basic_ar_count: got %0d want 2", arq.size()); else passes++;
        checks++; if (arq.size() < 2 || arq[0] !== 32'h1000 || arq[1] !== 32'h1020)
            $display("FAIL basic_ar_addrs: got %p want 1000,1020", arq); else passes++;
        checks++; if (wq.size() != 16) $display("FAIL basic_word_count: got %0d want 16", wq.size()); else passes++;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp_w, got_w;
            exp_w = word_at(32'h1000 + 32'(4*i));
            got_w = (i < wq.size()) ? wq[i] : 32'hxxxx_xxxx;
            checks++;
            if (got_w !== exp_w) $display("FAIL basic_word%0d: got %h want %h", i, got_w, exp_w);
            else passes++;
        end
        checks++; if (rptr !== 32'h1040) $display("FAIL basic_rptr: got %h want 00001040", rptr); else passes++;
        checks++; if (fifo_empty !== 1'b1) $display("FAIL basic_fifo_empty: got %b want 1", fifo_empty); else passes++;
        enable = 1'b0;
        cyc(2);
    endtask

    task automatic test_wrap;
        load_rptr(32'h1FE0);
        fifo_wptr = 32'h1020;
        arq.delete();
        wq.delete();
        enable = 1'b1;
        cyc(60);
        @(negedge clk);
        checks++; if (arq.size() != 2 || arq[0] !== 32'h1FE0 || arq[1] !== 32'h1000)
            $display("FAIL wrap_ar_addrs: got %p want 1fe0,1000", arq); else passes++;
        checks++; if (rptr !== 32'h1020) $display("FAIL wrap_rptr: got %h want 00001020", rptr); else passes++;
        checks++; if (wq.size() != 16 || wq[7] !== word_at(32'h1FFC) || wq[8] !== word_at(32'h1000))
            $display("FAIL wrap_words: got n=%0d w7=%h w8=%h want 16 %h %h", wq.size(),
                     (wq.size() > 7) ? wq[7] : 32'h0, (wq.size() > 8) ? wq[8] : 32'h0,
                     word_at(32'h1FFC), word_at(32'h1000));
            else passes++;
        enable = 1'b0;
        cyc(2);
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        cmd_ready = 1'b0;
        load_rptr(32'h1000);
        fifo_wptr = 32'h1800;
        arq.delete();
        wq.delete();
        enable = 1'b1;
        cyc(80);
        @(negedge clk);
        checks++; if (arq.size() != BUF_BEATS/2) $display("FAIL bp_ar_count: got %0d want %0d", arq.size(), BUF_BEATS/2); else passes++;
        checks++; if (rptr !== 32'h1040) $display("FAIL bp_rptr: got %h want 00001040", rptr); else passes++;
        checks++; if (cmd_valid !== 1'b1) $display("FAIL bp_cmd_valid: got %b want 1", cmd_valid); else passes++;
        checks++; if (cmd_data !== word_at(32'h1000)) $display("FAIL bp_cmd_data: got %h want %h", cmd_data, word_at(32'h1000)); else passes++;
        held = cmd_data;
        cyc(5);
        @(negedge clk);
        checks++; if (cmd_data !== word_at(32'h1000)) $display("FAIL bp_cmd_stable: got %h want %h", cmd_data, held); else passes++;
        cyc(1);
        enable    = 1'b0;
        cmd_ready = 1'b1;
        cyc(30);
        @(negedge clk);
        checks++; if (wq.size() != 16) $display("FAIL bp_drain_count: got %0d want 16", wq.size()); else passes++;
        checks++; if (wq.size() < 16 || wq[15] !== word_at(32'h103C))
            $display("FAIL bp_drain_last: got %h want %h", (wq.size() > 15) ? wq[15] : 32'h0, word_at(32'h103C));
            else passes++;
        checks++; if (arq.size() != 2) $display("FAIL bp_no_more_ar: got %0d want 2", arq.size()); else passes++;
        cyc(1);
    endtask

    task automatic test_error;
        load_rptr(32'h1000);
        fifo_wptr = 32'h1040;
        cmd_ready = 1'b1;
        arq.delete();
        wq.delete();
        err_inject = 1'b1;
        enable     = 1'b1;
        cyc(20);
        @(negedge clk);
        checks++; if (bus_err !== 1'b1) $display("FAIL err_bus_err: got %b want 1", bus_err); else passes++;
        checks++; if (rptr !== 32'h1000) $display("FAIL err_rptr: got %h want 00001000", rptr); else passes++;
        checks++; if (arq.size() != 1) $display("FAIL err_ar_count: got %0d want 1", arq.size()); else passes++;
        checks++; if (wq.size() != 0) $display("FAIL err_words_discarded: got %0d want 0", wq.size()); else passes++;
        checks++; if (arvalidm_a !== 1'b0) $display("FAIL err_no_ar: got %b want 0", arvalidm_a); else passes++;
        cyc(1);
        enable = 1'b0;
        cyc(2);
        @(negedge clk);
        checks++; if (bus_err !== 1'b0) $display("FAIL err_clear: got %b want 0", bus_err); else passes++;
        cyc(1);
        enable = 1'b1;
        cyc(40);
        @(negedge clk);
        checks++; if (arq.size() != 3 || rptr !== 32'h1040)
            $display("FAIL err_recover: got ar=%0d rptr=%h want 3 00001040", arq.size(), rptr); else passes++;
        cyc(1);
        enable = 1'b0;
        cyc(2);
    endtask

    task automatic test_load_mid;
        cmd_ready = 1'b0;
        load_rptr(32'h1000);
        fifo_wptr = 32'h1800;
        arq.delete();
        wq.delete();
        enable = 1'b1;
        wait_data("load");
        rptr_load       = 1'b1;
        rptr_load_value = 32'h1234;
        enable          = 1'b0;
        cyc(1);
        rptr_load = 1'b0;
        cyc(8);
        @(negedge clk);
        checks++; if (arq.size() != 1) $display("FAIL load_ar_count: got %0d want 1", arq.size()); else passes++;
        checks++; if (rptr !== 32'h1220) $display("FAIL load_rptr: got %h want 00001220", rptr); else passes++;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL load_flush: cmd_valid got %b want 0", cmd_valid); else passes++;
        checks++; if (rreadym_a !== 1'b0) $display("FAIL load_idle: rready got %b want 0", rreadym_a); else passes++;
        cyc(1);
    endtask

    task automatic test_breakpoint;
        cmd_ready = 1'b1;
        load_rptr(32'h1000);
        fifo_wptr = 32'h1060;
        bp_addr   = 32'h1020;
        bp_en     = 1'b1;
        arq.delete();
        wq.delete();
        enable = 1'b1;
        cyc(60);
        @(negedge clk);
`ifdef CP_FIFO_BREAKPOINT_EN
        checks++; if (bp_hit !== 1'b1) $display("FAIL brk_hit: got %b want 1", bp_hit); else passes++;
        checks++; if (arq.size() != 1) $display("FAIL brk_ar_count: got %0d want 1", arq.size()); else passes++;
        checks++; if (rptr !== 32'h1020) $display("FAIL brk_rptr: got %h want 00001020", rptr); else passes++;
        checks++; if (wq.size() != 8 || wq[7] !== word_at(32'h101C))
            $display("FAIL brk_drain: got n=%0d want 8", wq.size()); else passes++;
        cyc(1);
        bp_en = 1'b0;
        cyc(40);
        @(negedge clk);
        checks++; if (bp_hit !== 1'b0) $display("FAIL brk_clear: got %b want 0", bp_hit); else passes++;
        checks++; if (arq.size() != 3 || rptr !== 32'h1060)
            $display("FAIL brk_resume: got ar=%0d rptr=%h want 3 00001060", arq.size(), rptr); else passes++;
`else
        checks++; if (bp_hit !== 1'b0) $display("FAIL brk_tied: got %b want 0", bp_hit); else passes++;
        checks++; if (arq.size() != 3) $display("FAIL brk_ignored_ar: got %0d want 3", arq.size()); else passes++;
        checks++; if (rptr !== 32'h1060) $display("FAIL brk_ignored_rptr: got %h want 00001060", rptr); else passes++;
        checks++; if (wq.size() != 24) $display("FAIL brk_ignored_words: got %0d want 24", wq.size()); else passes++;
`endif
        cyc(1);
        enable = 1'b0;
        bp_en  = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_mid;
        cmd_ready = 1'b0;
        load_rptr(32'h1000);
        fifo_wptr = 32'h1040;
        enable    = 1'b1;
        wait_data("rstmid");
        resetn = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        checks++; if (rreadym_a !== 1'b0 || arvalidm_a !== 1'b0)
            $display("FAIL rstmid_axi: got rready=%b arvalid=%b want 0 0", rreadym_a, arvalidm_a); else passes++;
        checks++; if (rptr !== 32'h0) $display("FAIL rstmid_rptr: got %h want 0", rptr); else passes++;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL rstmid_cmd_valid: got %b want 0", cmd_valid); else passes++;
        cyc(5);
        resetn = 1'b1;
        cyc(2);
    endtask

    initial begin
        resetn          = 1'b0;
        enable          = 1'b0;
        fifo_base       = 32'h1000;
        fifo_end        = 32'h1FE0;
        fifo_wptr       = 32'h0;
        rptr_load       = 1'b0;
        rptr_load_value = 32'h0;
        cmd_ready       = 1'b0;
        bp_en           = 1'b0;
        bp_addr         = 32'h0;

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_error();
        test_load_mid();
        test_breakpoint();
        test_reset_mid();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
